// File: rtl/bus_decoder_pkg.sv
// Shared definitions for the bus interconnect blocks.
//   bus_state_t  : decoder FSM states (IDLE / ACTIVE / ERR)
//   BUS_ERR_DATA : default read data returned on a synthetic error ack
//   cnt_width()  : counter width able to hold 0..limit, minimum 1 bit
package bus_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } bus_state_t;

    localparam logic [15:0] BUS_ERR_DATA = 16'hDEAD;

    function automatic int cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/bus_decoder_if.sv
// Bus bundle between one master, the decoder and NSLAVES slaves.
// Signal names keep the decoder's original port names (i_* into the
// decoder, o_* out of it).
//   master modport : the environment side (CPU + slaves) driving the decoder
//   slave  modport : the decoder itself
//   i_m_addr/i_m_dat/i_m_we/i_m_cs : master request
//   o_m_dat/o_m_ack                : response to master
//   o_s_addr/o_s_dat/o_s_we/o_s_cs : fan-out to slaves
//   i_s_dat/i_s_ack                : packed slave responses
interface bus_decoder_if #(
    parameter int NSLAVES = 4,
    parameter int AW      = 16,
    parameter int DW      = 16
);

    logic [AW-1:0]         i_m_addr;
    logic [DW-1:0]         i_m_dat;
    logic                  i_m_we;
    logic                  i_m_cs;
    logic [DW-1:0]         o_m_dat;
    logic                  o_m_ack;
    logic [AW-1:0]         o_s_addr;
    logic [DW-1:0]         o_s_dat;
    logic                  o_s_we;
    logic [NSLAVES-1:0]    o_s_cs;
    logic [NSLAVES*DW-1:0] i_s_dat;
    logic [NSLAVES-1:0]    i_s_ack;

    modport master (
        output i_m_addr, i_m_dat, i_m_we, i_m_cs, i_s_dat, i_s_ack,
        input  o_m_dat, o_m_ack, o_s_addr, o_s_dat, o_s_we, o_s_cs
    );

    modport slave (
        input  i_m_addr, i_m_dat, i_m_we, i_m_cs, i_s_dat, i_s_ack,
        output o_m_dat, o_m_ack, o_s_addr, o_s_dat, o_s_we, o_s_cs
    );

endinterface

// File: rtl/bus_decoder_addr_match.sv
// Address window comparator for one slave channel.
//   addr : master address
//   hit  : high when (addr & MASK) == (BASE & MASK)
module bus_decoder_addr_match #(
    parameter int            AW   = 16,
    parameter logic [AW-1:0] BASE = '0,
    parameter logic [AW-1:0] MASK = '0
) (
    input  logic [AW-1:0] addr,
    output logic          hit
);

    assign hit = ((addr & MASK) == (BASE & MASK));

endmodule

// File: rtl/bus_decoder.sv
// Single-master to NSLAVES-slave bus interconnect.
// Decodes the master address against per-slave base/mask windows, registers
// the selected slave, routes read data/ack back, times out hung slaves and
// answers unmapped addresses with a synthetic error ack.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus            : bus_decoder_if slave modport (master request, slave fan-out)
//   i_err_clr      : clears the sticky error flag
//   o_err          : sticky flag, set on unmapped access or timeout
//   o_err_addr     : address of the most recent error
module bus_decoder
    import bus_decoder_pkg::*;
#(
    parameter int                    NSLAVES    = 4,
    parameter int                    AW         = 16,
    parameter int                    DW         = 16,
    parameter logic [NSLAVES*AW-1:0] SLAVE_BASE = '0,
    parameter logic [NSLAVES*AW-1:0] SLAVE_MASK = '0,
    parameter int unsigned           TIMEOUT    = 255,
    parameter logic [15:0]           ERR_DATA   = BUS_ERR_DATA
) (
    input  logic          i_clk,
    input  logic          i_reset,
    bus_decoder_if.slave  bus,
    input  logic          i_err_clr,
    output logic          o_err,
    output logic [AW-1:0] o_err_addr
);

    localparam int            SW       = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [DW-1:0] ERR_WORD = DW'(ERR_DATA);

    bus_state_t         state;
    logic [SW-1:0]      sel;
    logic [NSLAVES-1:0] s_cs;
    logic [CW-1:0]      cnt;
    logic               err;
    logic [AW-1:0]      err_addr;

    logic [NSLAVES-1:0] hit;
    logic [SW-1:0]      hit_idx;
    logic               any_hit;
    logic               sel_ack;
    logic [DW-1:0]      sel_dat;

    for (genvar k = 0; k < NSLAVES; k++) begin : g_match
        bus_decoder_addr_match #(
            .AW   (AW),
            .BASE (SLAVE_BASE[k*AW +: AW]),
            .MASK (SLAVE_MASK[k*AW +: AW])
        ) u_match (
            .addr (bus.i_m_addr),
            .hit  (hit[k])
        );
    end

    // Scan from the top so the lowest-index hit is the last one written.
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        for (int unsigned k = NSLAVES; k > 0; k--) begin
            if (hit[k-1]) begin
                hit_idx = SW'(k - 1);
                any_hit = 1'b1;
            end
        end
    end

    // Response mux for the registered selection; acks from other slaves
    // never reach the master.
    always_comb begin
        sel_dat = '0;
        sel_ack = 1'b0;
        for (int unsigned k = 0; k < NSLAVES; k++) begin
            if (sel == SW'(k)) begin
                sel_dat = bus.i_s_dat[k*DW +: DW];
                sel_ack = bus.i_s_ack[k] && (state == ST_ACTIVE);
            end
        end
    end

    assign bus.o_m_ack  = sel_ack || (state == ST_ERR);
    assign bus.o_m_dat  = sel_ack ? sel_dat : ((state == ST_ERR) ? ERR_WORD : '0);
    assign bus.o_s_addr = bus.i_m_addr;
    assign bus.o_s_dat  = bus.i_m_dat;
    assign bus.o_s_we   = bus.i_m_we;
    assign bus.o_s_cs   = s_cs;
    assign o_err        = err;
    assign o_err_addr   = err_addr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            sel      <= '0;
            s_cs     <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_m_cs) begin
                        if (any_hit) begin
                            state <= ST_ACTIVE;
                            sel   <= hit_idx;
                            s_cs  <= NSLAVES'(1) << hit_idx;
                            cnt   <= '0;
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Ack beats abort and timeout; cnt holds the number of
                    // prior ACTIVE cycles, so CNT_LAST marks the TIMEOUT-th.
                    if (sel_ack || !bus.i_m_cs) begin
                        state <= ST_IDLE;
                        s_cs  <= '0;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        state <= ST_ERR;
                        s_cs  <= '0;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    s_cs  <= '0;
                end
            endcase

            // A new error outranks a simultaneous clear.
            if (state == ST_ERR) begin
                err      <= 1'b1;
                err_addr <= bus.i_m_addr;
            end else if (i_err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Randomized self-checking bench for bus_decoder (2 slaves, TIMEOUT 8).
// The reference model predicts each transfer's outcome (selected slave,
// ack cycle, data, error) from the window rules; the bench plays the slaves.
module tb_bus_decoder;

    localparam int          NS = 2;
    localparam int          AW = 16;
    localparam int          DW = 16;
    localparam int unsigned TO = 8;

    localparam logic [NS*AW-1:0] BASES = {16'hFFFE, 16'h0000};
    localparam logic [NS*AW-1:0] MASKS = {16'hFFFE, 16'hF000};

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_err_clr;
    logic          o_err;
    logic [AW-1:0] o_err_addr;

    bus_decoder_if #(.NSLAVES(NS), .AW(AW), .DW(DW)) bus ();

    bus_decoder #(
        .NSLAVES    (NS),
        .AW         (AW),
        .DW         (DW),
        .SLAVE_BASE (BASES),
        .SLAVE_MASK (MASKS),
        .TIMEOUT    (TO),
        .ERR_DATA   (16'hDEAD)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .bus        (bus.slave),
        .i_err_clr  (i_err_clr),
        .o_err      (o_err),
        .o_err_addr (o_err_addr)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: window table and sticky error state.
    logic [15:0] m_base [NS] = '{16'h0000, 16'hFFFE};
    logic [15:0] m_mask [NS] = '{16'hF000, 16'hFFFE};
    logic        m_err      = 1'b0;
    logic [15:0] m_err_addr = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int decode(input logic [15:0] a);
        for (int k = 0; k < NS; k++)
            if ((a & m_mask[k]) == (m_base[k] & m_mask[k])) return k;
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic cs, input logic [15:0] a, input logic we,
                         input logic [15:0] d, input logic [1:0] ack,
                         input logic [15:0] sd0, input logic [15:0] sd1, input logic clr);
        bus.i_m_cs   = cs;
        bus.i_m_addr = a;
        bus.i_m_we   = we;
        bus.i_m_dat  = d;
        bus.i_s_ack  = ack;
        bus.i_s_dat  = {sd1, sd0};
        i_err_clr    = clr;
    endtask

    // Called at the negedge; then advances the model with this cycle's inputs.
    task automatic check_bus(input string tag, input logic [1:0] exp_cs, input logic exp_ack,
                             input logic [15:0] exp_dat, input logic err_cycle);
        check({tag, ".s_cs"},   32'(bus.o_s_cs),   32'(exp_cs));
        check({tag, ".ack"},    32'(bus.o_m_ack),  32'(exp_ack));
        check({tag, ".m_dat"},  32'(bus.o_m_dat),  32'(exp_dat));
        check({tag, ".s_addr"}, 32'(bus.o_s_addr), 32'(bus.i_m_addr));
        check({tag, ".s_dat"},  32'(bus.o_s_dat),  32'(bus.i_m_dat));
        check({tag, ".s_we"},   32'(bus.o_s_we),   32'(bus.i_m_we));
        check({tag, ".err"},    32'(o_err),        32'(m_err));
        check({tag, ".eaddr"},  32'(o_err_addr),   32'(m_err_addr));
        if (err_cycle) begin
            m_err      = 1'b1;
            m_err_addr = bus.i_m_addr;
        end else if (i_err_clr) begin
            m_err = 1'b0;
        end
    endtask

    // clr_mode: 0 never, 1 random, 2 always. lat: cycle after cs start at
    // which the selected slave acks; 0 or > TO means it never acks.
    task automatic xfer(input string tag, input logic [15:0] a, input logic we,
                        input logic [15:0] wd, input int lat, input bit noise,
                        input int clr_mode, input int fixed_dat);
        int          sel;
        int          ack_off;
        bit          to_err;
        logic [1:0]  ack;
        logic [15:0] sd [2];
        logic [1:0]  exp_cs;
        logic [15:0] exp_d;
        logic        clr;
        sel = decode(a);
        if (sel < 0) begin
            ack_off = 1;
            to_err  = 1'b1;
        end else if (lat >= 1 && lat <= int'(TO)) begin
            ack_off = lat;
            to_err  = 1'b0;
        end else begin
            ack_off = int'(TO) + 1;
            to_err  = 1'b1;
        end
        for (int off = 0; off <= ack_off; off++) begin
            next_cycle();
            sd[0] = 16'($urandom);
            sd[1] = 16'($urandom);
            if (sel >= 0 && fixed_dat >= 0) sd[sel] = 16'(fixed_dat);
            ack = noise ? 2'($urandom) : 2'b00;
            if (sel >= 0) ack[sel] = (off == ack_off) && !to_err;
            clr = (clr_mode == 2) ? 1'b1 : (clr_mode == 1) ? 1'($urandom) : 1'b0;
            drive(1'b1, a, we, wd, ack, sd[0], sd[1], clr);
            @(negedge i_clk);
            exp_cs = 2'b00;
            if (sel >= 0 && off >= 1 && !(to_err && off == ack_off)) exp_cs[sel] = 1'b1;
            exp_d = 16'h0000;
            if (off == ack_off) exp_d = to_err ? 16'hDEAD : sd[sel];
            check_bus(tag, exp_cs, off == ack_off, exp_d, to_err && off == ack_off);
        end
    endtask

    task automatic idle(input string tag, input int clr_mode);
        logic clr;
        next_cycle();
        clr = (clr_mode == 2) ? 1'b1 : (clr_mode == 1) ? 1'($urandom) : 1'b0;
        drive(1'b0, 16'($urandom), 1'($urandom), 16'($urandom), 2'($urandom),
              16'($urandom), 16'($urandom), clr);
        @(negedge i_clk);
        check_bus(tag, 2'b00, 1'b0, 16'h0000, 1'b0);
    endtask

    // Hold cs for n ACTIVE cycles with no ack, then drop it.
    task automatic abort(input string tag, input logic [15:0] a, input int n);
        int         sel;
        logic [1:0] exp_cs;
        logic [1:0] ack;
        sel = decode(a);
        for (int off = 0; off <= n + 1; off++) begin
            next_cycle();
            ack = 2'($urandom);
            ack[sel] = 1'b0;
            drive(off <= n, a, 1'b0, 16'h0000, ack, 16'($urandom), 16'($urandom), 1'b0);
            @(negedge i_clk);
            exp_cs = 2'b00;
            if (off >= 1) exp_cs[sel] = 1'b1;
            check_bus(tag, exp_cs, 1'b0, 16'h0000, 1'b0);
        end
        idle({tag, ".after"}, 0);
    endtask

    task automatic reset_mid(input string tag, input logic [15:0] a);
        int         sel;
        logic [1:0] exp_cs;
        sel = decode(a);
        for (int off = 0; off <= 2; off++) begin
            next_cycle();
            drive(1'b1, a, 1'b0, 16'h0000, 2'b00, 16'h1111, 16'h2222, 1'b0);
            i_reset = (off == 2);
            @(negedge i_clk);
            exp_cs = 2'b00;
            if (off >= 1) exp_cs[sel] = 1'b1;
            check_bus(tag, exp_cs, 1'b0, 16'h0000, 1'b0);
        end
        m_err      = 1'b0;
        m_err_addr = 16'h0000;
        next_cycle();
        i_reset = 1'b0;
        drive(1'b0, a, 1'b0, 16'h0000, 2'b00, 16'h1111, 16'h2222, 1'b0);
        @(negedge i_clk);
        check_bus({tag, ".post"}, 2'b00, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        logic [15:0] a;
        i_reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        idle("reset", 0);

        xfer("rd_s0",    16'h0123, 1'b0, 16'h0000, 2, 1'b0, 0, 16'h1234);
        xfer("wr_s1",    16'hFFFF, 1'b1, 16'h0041, 1, 1'b1, 0, -1);
        idle("gap", 0);
        xfer("unmapped", 16'h8000, 1'b0, 16'h0000, 0, 1'b1, 0, -1);
        xfer("timeout",  16'h0010, 1'b0, 16'h0000, 0, 1'b1, 0, -1);
        xfer("ack_last", 16'h0010, 1'b0, 16'h0000, int'(TO), 1'b1, 0, -1);
        xfer("b2b",      16'hFFFE, 1'b0, 16'h0000, 3, 1'b1, 0, -1);
        abort("abort", 16'h0FFF, 3);
        reset_mid("rst_mid", 16'h0200);
        xfer("unmap2",   16'h9000, 1'b0, 16'h0000, 0, 1'b0, 0, -1);
        idle("clr", 2);
        idle("clr_chk", 0);
        xfer("clr_vs_set", 16'h4000, 1'b0, 16'h0000, 0, 1'b0, 2, -1);
        idle("set_wins", 0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0:       a = {4'h0, 12'($urandom)};
                1:       a = {15'h7FFF, 1'($urandom)};
                default: a = 16'($urandom);
            endcase
            xfer("rnd", a, 1'($urandom), 16'($urandom), int'($urandom_range(0, TO + 1)), 1'b1, 1, -1);
            if ($urandom_range(0, 2) == 0) idle("rnd_idle", 1);
            if ($urandom_range(0, 9) == 0)
                abort("rnd_abort", {4'h0, 12'($urandom)}, int'($urandom_range(1, TO - 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
